// File: rtl/bus_cycle_sequencer_pkg.sv
// Shared types, constants and decode helpers for the 8088-style bus cycle sequencer.
package bus_cycle_sequencer_pkg;

  typedef enum logic [2:0] {
    BT_MEM_RD = 3'd0,
    BT_MEM_WR = 3'd1,
    BT_IO_RD  = 3'd2,
    BT_IO_WR  = 3'd3,
    BT_INTA   = 3'd4
  } bus_type_t;

  typedef enum logic [2:0] {
    TI = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    TW = 3'd4,
    T4 = 3'd5
  } t_state_t;

  localparam logic [7:0] IDLE_DATA = 8'hFF;

  // Unused encodings fall back to a memory read
  function automatic bus_type_t decode_type(input logic [2:0] raw);
    case (raw)
      3'd1:    decode_type = BT_MEM_WR;
      3'd2:    decode_type = BT_IO_RD;
      3'd3:    decode_type = BT_IO_WR;
      3'd4:    decode_type = BT_INTA;
      default: decode_type = BT_MEM_RD;
    endcase
  endfunction

  function automatic logic is_io(input bus_type_t bt);
    is_io = (bt == BT_IO_RD) || (bt == BT_IO_WR) || (bt == BT_INTA);
  endfunction

  function automatic logic is_write(input bus_type_t bt);
    is_write = (bt == BT_MEM_WR) || (bt == BT_IO_WR);
  endfunction

  function automatic logic uses_rd_strobe(input bus_type_t bt);
    uses_rd_strobe = (bt == BT_MEM_RD) || (bt == BT_IO_RD);
  endfunction

  function automatic logic captures_data(input bus_type_t bt);
    captures_data = uses_rd_strobe(bt) || (bt == BT_INTA);
  endfunction

endpackage

// File: rtl/bus_cycle_sequencer.sv
// Runs one T1..T4 bus cycle per request (two for INTA), inserting Tw states from RDY
// and bounding them with WAIT_LIMIT. All outputs come straight from registers.
module bus_cycle_sequencer
  import bus_cycle_sequencer_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_cpu_clock_posedge,
  input  logic                  i_cpu_clock_negedge,
  input  logic                  i_req,
  input  logic [2:0]            i_req_type,
  input  logic [ADDR_WIDTH-1:0] i_req_address,
  input  logic [7:0]            i_req_wdata,
  output logic                  o_ack,
  output logic [7:0]            o_rdata,
  output logic                  o_timeout,
  output logic                  o_ale,
  output logic                  o_io_or_m,
  output logic                  o_rd_n,
  output logic                  o_wr_n,
  output logic                  o_inta_n,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic [7:0]            o_data_out,
  output logic                  o_data_oe,
  input  logic [7:0]            i_data_in,
  input  logic                  i_rdy
);

  localparam logic [7:0] LP_WAIT_LIMIT = 8'(WAIT_LIMIT);

  t_state_t              r_state;
  bus_type_t             r_type;
  logic [7:0]            r_wait_cnt;
  logic [7:0]            r_capture;
  logic [7:0]            r_rdata;
  logic                  r_inta_phase;
  logic                  r_to_seen;
  logic                  r_ack;
  logic                  r_timeout;
  logic                  r_ale;
  logic                  r_io_or_m;
  logic                  r_rd_n;
  logic                  r_wr_n;
  logic                  r_inta_n;
  logic                  r_data_oe;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [7:0]            r_data_out;

  bus_type_t w_req_type;
  logic      w_cycle_done;
  logic      w_wait_expired;
  logic      w_start;

  // Decode of the incoming request and of the cycle-completion conditions
  always_comb begin
    w_req_type     = decode_type(i_req_type);
    w_cycle_done   = (r_state == T4) && !((r_type == BT_INTA) && !r_inta_phase);
    w_wait_expired = (r_state == TW) && (r_wait_cnt == LP_WAIT_LIMIT) && !i_rdy;
    w_start        = i_cpu_clock_posedge && i_req && ((r_state == TI) || w_cycle_done);
  end

  // Request latch: a new transfer starts from TI or directly out of a finished T4
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_type     <= BT_MEM_RD;
      r_address  <= {ADDR_WIDTH{1'b0}};
      r_data_out <= 8'h00;
      r_io_or_m  <= 1'b0;
    end else if (w_start) begin
      r_type     <= w_req_type;
      r_address  <= i_req_address;
      r_data_out <= i_req_wdata;
      r_io_or_m  <= is_io(w_req_type);
    end
  end

  // T-state sequencer: state moves on CPU rising edges, read strobes and data_oe release on falling edges
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= TI;
      r_wait_cnt   <= 8'd0;
      r_capture    <= IDLE_DATA;
      r_rdata      <= IDLE_DATA;
      r_inta_phase <= 1'b0;
      r_to_seen    <= 1'b0;
      r_ack        <= 1'b0;
      r_timeout    <= 1'b0;
      r_ale        <= 1'b0;
      r_rd_n       <= 1'b1;
      r_wr_n       <= 1'b1;
      r_inta_n     <= 1'b1;
      r_data_oe    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (i_cpu_clock_posedge) begin
        case (r_state)
          TI: begin
            if (i_req) begin
              r_state      <= T1;
              r_ale        <= 1'b1;
              r_wait_cnt   <= 8'd0;
              r_to_seen    <= 1'b0;
              r_inta_phase <= 1'b0;
              r_timeout    <= 1'b0;
            end
          end
          T1: begin
            r_state   <= T2;
            r_ale     <= 1'b0;
            r_timeout <= 1'b0;
            if (is_write(r_type)) begin
              r_wr_n    <= 1'b0;
              r_data_oe <= 1'b1;
            end
          end
          T2: r_state <= T3;
          T3, TW: begin
            if (i_rdy || w_wait_expired) begin
              r_state   <= T4;
              r_capture <= i_rdy ? i_data_in : IDLE_DATA;
              r_rd_n    <= 1'b1;
              r_wr_n    <= 1'b1;
              r_inta_n  <= 1'b1;
              if (!i_rdy) begin
                r_to_seen <= 1'b1;
              end
            end else begin
              r_state    <= TW;
              r_wait_cnt <= r_wait_cnt + 8'd1;
            end
          end
          T4: begin
            if (!w_cycle_done) begin
              // First INTA cycle done: its data is dropped and the second cycle follows
              r_inta_phase <= 1'b1;
              r_state      <= T1;
              r_ale        <= 1'b1;
              r_wait_cnt   <= 8'd0;
            end else begin
              r_ack        <= 1'b1;
              r_timeout    <= r_to_seen;
              r_inta_phase <= 1'b0;
              if (captures_data(r_type)) begin
                r_rdata <= r_capture;
              end
              if (i_req) begin
                r_state    <= T1;
                r_ale      <= 1'b1;
                r_wait_cnt <= 8'd0;
                r_to_seen  <= 1'b0;
              end else begin
                r_state <= TI;
              end
            end
          end
          default: r_state <= TI;
        endcase
      end else if (i_cpu_clock_negedge) begin
        case (r_state)
          T2: begin
            if (uses_rd_strobe(r_type)) begin
              r_rd_n <= 1'b0;
            end
            if (r_type == BT_INTA) begin
              r_inta_n <= 1'b0;
            end
          end
          T4:      r_data_oe <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign o_ack      = r_ack;
  assign o_rdata    = r_rdata;
  assign o_timeout  = r_timeout;
  assign o_ale      = r_ale;
  assign o_io_or_m  = r_io_or_m;
  assign o_rd_n     = r_rd_n;
  assign o_wr_n     = r_wr_n;
  assign o_inta_n   = r_inta_n;
  assign o_address  = r_address;
  assign o_data_out = r_data_out;
  assign o_data_oe  = r_data_oe;

endmodule

// File: doc/bus_cycle_sequencer.md
Name: bus_cycle_sequencer

Overview:
CPU-side bus interface that runs 8088-style bus cycles and consumes the RDY line from the ready-synchroniser block.
- Accepts one transfer request at a time (memory/IO read/write, interrupt acknowledge).
- Sequences T1..T4 states and asserts ALE, the strobes, IO_OR_M and INTA_N.
- Samples RDY in T3/Tw to insert wait states, returns read data with a one-clock ack.
- Sits between the CPU core model and the system bus decode / ready logic.

Parameters:
WAIT_LIMIT, 255, max consecutive Tw states before forced completion (1..255)
ADDR_WIDTH, 20, bus address width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_clock_posedge  in  1  one-clock enable at CPU clock rising edge; all T-state advances happen here
cpu_clock_negedge  in  1  one-clock enable at CPU clock falling edge; strobe timing only
req  in  1  transfer request; held until ack
req_type  in  3  0=MEM_RD 1=MEM_WR 2=IO_RD 3=IO_WR 4=INTA; others treated as MEM_RD
req_address  in  ADDR_WIDTH  transfer address
req_wdata  in  8  write data
ack  out  1  one-clock pulse, transfer complete
rdata  out  8  read / vector data, valid from ack, held until next ack
timeout  out  1  sticky-per-transfer, set with ack when WAIT_LIMIT hit
ALE  out  1  address latch enable
IO_OR_M  out  1  1=IO cycle, 0=memory cycle
RD_N  out  1  read strobe, active low
WR_N  out  1  write strobe, active low
INTA_N  out  1  interrupt acknowledge strobe, active low
address  out  ADDR_WIDTH  bus address
data_out  out  8  write data
data_oe  out  1  data_out drive enable
data_in  in  8  bus read data
RDY  in  1  ready from ready-synchroniser

Behaviour:
- Reset: state TI, ack=0, rdata=8'hFF, timeout=0, ALE=0, IO_OR_M=0, RD_N=WR_N=INTA_N=1, address=0, data_out=0, data_oe=0, wait count=0, inta phase=0. Reset wins over any enable in the same clock; mid-cycle reset aborts the cycle with no ack.
- State changes only on clocks where cpu_clock_posedge=1; otherwise all registers hold, except the strobe updates described below.
- TI: if req=1 -> T1; latch address, type, wdata.
- T1: ALE=1, address and IO_OR_M driven. -> T2.
- T2: ALE=0. Strobe asserts at the first cpu_clock_negedge in T2: RD_N for read types, INTA_N for INTA. WR_N and data_oe assert together on entry to T2. -> T3.
- T3 and TW: on posedge, RDY=1 -> T4 and capture data_in into rdata for read and INTA types; RDY=0 -> TW and increment wait count.
- TW: when wait count = WAIT_LIMIT and RDY=0 -> T4 anyway; rdata=8'hFF for reads; timeout=1.
- T4: strobes deassert on entry. data_oe drops at the cpu_clock_negedge in T4.
  - INTA, phase 0: set phase 1, -> T1 (second INTA cycle, no ack). Phase-0 data is discarded.
  - Otherwise: ack=1 for exactly one clock; -> TI, or straight to T1 if req is still high on the clock after ack.
- timeout clears on the next T1.
- Minimum cycle with RDY held 1 is 4 CPU clocks. Each Tw adds 1 CPU clock. INTA with no waits takes 8 CPU clocks.
- IO_OR_M=1 for IO_RD, IO_WR and INTA. It holds its value through TI after a cycle.
- req deasserted mid-cycle: the cycle still completes and acks.

Decomposition:
- Shared package: bus_type_t enum (MEM_RD..INTA), t_state_t enum (TI,T1,T2,T3,TW,T4), constant IDLE_DATA=8'hFF.
- No sub-module. The wait counter stays inline; the datapath is too small to justify splitting.

Test Plan:
1. MEM_RD at 0x12345, RDY=1 throughout, data_in=0xA5 -> ALE high exactly in T1; RD_N low from T2-negedge to T4; ack after 4 CPU clocks; rdata=0xA5; IO_OR_M=0.
2. IO_WR at 0x0061 with data 0x3C, RDY low for 3 T3 samples -> 3 Tw states; WR_N low T2..T4; data_out=0x3C; ack after 7 CPU clocks; IO_OR_M=1.
3. INTA, data_in=0x11 in first cycle and 0x08 in second -> two ALE pulses; INTA_N low twice; single ack; rdata=0x08.
4. WAIT_LIMIT=4, RDY stuck 0, IO_RD -> exactly 4 Tw; ack with timeout=1 and rdata=0xFF; next request clears timeout.
5. req held high across two MEM_WR -> second T1 follows T4 directly, no TI; two acks 4 CPU clocks apart.
6. reset asserted during TW -> next clock all outputs at reset values, no ack; a new req after reset completes normally.
